// File: rtl/gcd_ctrl_pkg.sv
// Shared definitions for the binary-GCD (Stein) sequencer: token indices,
// one-hot token encodings and the k-counter width derivation.
package gcd_ctrl_pkg;

    localparam int unsigned NUM_TOKENS = 13;

    localparam int unsigned T_IDLE  = 0;
    localparam int unsigned T_LOAD  = 1;
    localparam int unsigned T_ZCHK  = 2;
    localparam int unsigned T_EVCHK = 3;
    localparam int unsigned T_SH_AB = 4;
    localparam int unsigned T_SH_A  = 5;
    localparam int unsigned T_BCHK  = 6;
    localparam int unsigned T_SH_B  = 7;
    localparam int unsigned T_SWAP  = 8;
    localparam int unsigned T_SUB   = 9;
    localparam int unsigned T_OUT   = 10;
    localparam int unsigned T_SHL   = 11;
    localparam int unsigned T_DONE  = 12;

    typedef logic [NUM_TOKENS-1:0] token_t;

    localparam logic [NUM_TOKENS-1:0] TOK_IDLE  = NUM_TOKENS'(1) << T_IDLE;
    localparam logic [NUM_TOKENS-1:0] TOK_LOAD  = NUM_TOKENS'(1) << T_LOAD;
    localparam logic [NUM_TOKENS-1:0] TOK_ZCHK  = NUM_TOKENS'(1) << T_ZCHK;
    localparam logic [NUM_TOKENS-1:0] TOK_EVCHK = NUM_TOKENS'(1) << T_EVCHK;
    localparam logic [NUM_TOKENS-1:0] TOK_SH_AB = NUM_TOKENS'(1) << T_SH_AB;
    localparam logic [NUM_TOKENS-1:0] TOK_SH_A  = NUM_TOKENS'(1) << T_SH_A;
    localparam logic [NUM_TOKENS-1:0] TOK_BCHK  = NUM_TOKENS'(1) << T_BCHK;
    localparam logic [NUM_TOKENS-1:0] TOK_SH_B  = NUM_TOKENS'(1) << T_SH_B;
    localparam logic [NUM_TOKENS-1:0] TOK_SWAP  = NUM_TOKENS'(1) << T_SWAP;
    localparam logic [NUM_TOKENS-1:0] TOK_SUB   = NUM_TOKENS'(1) << T_SUB;
    localparam logic [NUM_TOKENS-1:0] TOK_OUT   = NUM_TOKENS'(1) << T_OUT;
    localparam logic [NUM_TOKENS-1:0] TOK_SHL   = NUM_TOKENS'(1) << T_SHL;
    localparam logic [NUM_TOKENS-1:0] TOK_DONE  = NUM_TOKENS'(1) << T_DONE;

    // k holds at most WIDTH-1; never let the counter collapse to zero bits.
    function automatic int unsigned calc_kw(input int unsigned width);
        if (width <= 2)
            return 1;
        return $clog2(width);
    endfunction

endpackage

// File: rtl/gcd_k_counter.sv
// Up/down counter for the common power-of-two factor k, with clear and
// zero/one detection used by the sequencer's output stage.
module gcd_k_counter
    import gcd_ctrl_pkg::*;
#(
    parameter int unsigned KW = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic one
);

    logic [KW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc && !dec)
            count <= count + KW'(1);
        else if (dec && !inc)
            count <= count - KW'(1);
    end

    assign zero = (count == '0);
    assign one  = (count == KW'(1));

endmodule

// File: rtl/gcd_onehot_controller.sv
// One-hot sequencer for the binary-GCD datapath: next-token logic, Moore
// strobe decode, result-source flag and the k power-of-two counter.
module gcd_onehot_controller
    import gcd_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic a_zero,
    input  logic b_zero,
    input  logic a_lsb,
    input  logic b_lsb,
    input  logic a_gt_b,
    output logic ld_ab,
    output logic sh_a,
    output logic sh_b,
    output logic swap_ab,
    output logic sub_ba,
    output logic ld_res,
    output logic res_sel,
    output logic shl_res,
    output logic busy,
    output logic done
);

    localparam int unsigned KW = calc_kw(WIDTH);

    token_t token_q;
    token_t token_nxt;
    logic   res_sel_q;
    logic   res_sel_nxt;
    logic   k_zero;
    logic   k_one;

    // Full-vector compares: an empty or multi-hot token falls to default.
    always_comb begin
        token_nxt   = TOK_IDLE;
        res_sel_nxt = res_sel_q;
        case (token_q)
            TOK_IDLE: begin
                token_nxt = start ? TOK_LOAD : TOK_IDLE;
            end
            TOK_LOAD: begin
                token_nxt   = TOK_ZCHK;
                res_sel_nxt = 1'b0;
            end
            TOK_ZCHK: begin
                if (a_zero) begin
                    token_nxt   = TOK_OUT;
                    res_sel_nxt = 1'b1;
                end else if (b_zero) begin
                    token_nxt   = TOK_OUT;
                    res_sel_nxt = 1'b0;
                end else begin
                    token_nxt = TOK_EVCHK;
                end
            end
            TOK_EVCHK: begin
                if (!a_lsb && !b_lsb)
                    token_nxt = TOK_SH_AB;
                else if (!a_lsb)
                    token_nxt = TOK_SH_A;
                else
                    token_nxt = TOK_BCHK;
            end
            TOK_SH_AB: token_nxt = TOK_EVCHK;
            TOK_SH_A:  token_nxt = TOK_EVCHK;
            TOK_BCHK: begin
                if (b_zero) begin
                    token_nxt   = TOK_OUT;
                    res_sel_nxt = 1'b0;
                end else if (!b_lsb) begin
                    token_nxt = TOK_SH_B;
                end else if (a_gt_b) begin
                    token_nxt = TOK_SWAP;
                end else begin
                    token_nxt = TOK_SUB;
                end
            end
            TOK_SH_B: token_nxt = TOK_BCHK;
            TOK_SWAP: token_nxt = TOK_SUB;
            TOK_SUB:  token_nxt = TOK_BCHK;
            TOK_OUT: begin
                token_nxt = k_zero ? TOK_DONE : TOK_SHL;
            end
            TOK_SHL: begin
                // k_one is the pre-decrement value: this is the last shift.
                token_nxt = k_one ? TOK_DONE : TOK_SHL;
            end
            TOK_DONE: token_nxt = TOK_IDLE;
            default:  token_nxt = TOK_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            token_q   <= TOK_IDLE;
            res_sel_q <= 1'b0;
        end else begin
            token_q   <= token_nxt;
            res_sel_q <= res_sel_nxt;
        end
    end

    gcd_k_counter #(
        .KW (KW)
    ) u_kcnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (token_q == TOK_LOAD),
        .inc  (token_q == TOK_SH_AB),
        .dec  (token_q == TOK_SHL),
        .zero (k_zero),
        .one  (k_one)
    );

    assign ld_ab   = (token_q == TOK_LOAD);
    assign sh_a    = (token_q == TOK_SH_AB) || (token_q == TOK_SH_A);
    assign sh_b    = (token_q == TOK_SH_AB) || (token_q == TOK_SH_B);
    assign swap_ab = (token_q == TOK_SWAP);
    assign sub_ba  = (token_q == TOK_SUB);
    assign ld_res  = (token_q == TOK_OUT);
    assign res_sel = res_sel_q;
    assign shl_res = (token_q == TOK_SHL);
    assign busy    = (token_q != TOK_IDLE);
    assign done    = (token_q == TOK_DONE);

endmodule

// File: tb/tb_gcd_onehot_controller.sv
// Directed bench: a behavioural Stein datapath closes the loop around the
// controller; per-run strobe counts, latency and result are compared.
module tb_gcd_onehot_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic a_zero, b_zero, a_lsb, b_lsb, a_gt_b;
    logic ld_ab, sh_a, sh_b, swap_ab, sub_ba, ld_res, res_sel, shl_res, busy, done;

    always #5 clk = ~clk;

    gcd_onehot_controller #(
        .WIDTH (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_zero  (a_zero),
        .b_zero  (b_zero),
        .a_lsb   (a_lsb),
        .b_lsb   (b_lsb),
        .a_gt_b  (a_gt_b),
        .ld_ab   (ld_ab),
        .sh_a    (sh_a),
        .sh_b    (sh_b),
        .swap_ab (swap_ab),
        .sub_ba  (sub_ba),
        .ld_res  (ld_res),
        .res_sel (res_sel),
        .shl_res (shl_res),
        .busy    (busy),
        .done    (done)
    );

    // Behavioural operand/result datapath driven by the strobes.
    logic [7:0] in_a = '0, in_b = '0;
    logic [7:0] ra = '0, rb = '0, res = '0;

    always @(posedge clk) begin
        if (ld_ab) begin
            ra <= in_a;
            rb <= in_b;
        end else if (swap_ab) begin
            ra <= rb;
            rb <= ra;
        end else if (sub_ba) begin
            rb <= rb - ra;
        end else begin
            if (sh_a) ra <= ra >> 1;
            if (sh_b) rb <= rb >> 1;
        end
        if (ld_res)
            res <= res_sel ? rb : ra;
        else if (shl_res)
            res <= res << 1;
    end

    assign a_zero = (ra == 8'd0);
    assign b_zero = (rb == 8'd0);
    assign a_lsb  = ra[0];
    assign b_lsb  = rb[0];
    assign a_gt_b = (ra > rb);

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int cnt_ld, cnt_shab, cnt_sha, cnt_shb, cnt_swap, cnt_sub, cnt_ldres, cnt_shl;
    int busy_low, done_cyc, rs_at_ld;
    bit got_done;

    // Assumes entry right after a falling edge; first sample is the LOAD cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold);
        int cyc;
        in_a = a;
        in_b = b;
        start = 1'b1;
        cyc = 0;
        cnt_ld = 0; cnt_shab = 0; cnt_sha = 0; cnt_shb = 0; cnt_swap = 0;
        cnt_sub = 0; cnt_ldres = 0; cnt_shl = 0; busy_low = 0;
        done_cyc = 0; rs_at_ld = -1; got_done = 0;
        for (int t = 0; t < 1000 && !got_done; t++) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            if (ld_ab) cnt_ld++;
            if (sh_a && sh_b) cnt_shab++;
            else if (sh_a) cnt_sha++;
            else if (sh_b) cnt_shb++;
            if (swap_ab) cnt_swap++;
            if (sub_ba) cnt_sub++;
            if (ld_res) begin
                cnt_ldres++;
                rs_at_ld = int'(res_sel);
            end
            if (shl_res) cnt_shl++;
            if (!busy) busy_low++;
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        int         cyc;
        int         shab;
        int         sha;
        int         shb;
        int         swp;
        int         sub;
        int         shl;
        int         rs;
    } vec_t;

    vec_t vecs[7];

    initial begin
        //          a       b       res     cyc shab sha shb swp sub shl rs
        vecs[0] = '{8'd12,  8'd18,  8'd6,   17, 1,   1,  1,  0,  2,  1,  0};
        vecs[1] = '{8'd0,   8'd7,   8'd7,   4,  0,   0,  0,  0,  0,  0,  1};
        vecs[2] = '{8'd128, 8'd64,  8'd64,  28, 6,   1,  0,  0,  1,  6,  0};
        vecs[3] = '{8'd9,   8'd6,   8'd3,   15, 0,   0,  2,  1,  2,  0,  0};
        vecs[4] = '{8'd7,   8'd0,   8'd7,   4,  0,   0,  0,  0,  0,  0,  0};
        vecs[5] = '{8'd0,   8'd0,   8'd0,   4,  0,   0,  0,  0,  0,  0,  1};
        vecs[6] = '{8'd5,   8'd5,   8'd5,   8,  0,   0,  0,  0,  1,  0,  0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset res_sel", int'(res_sel), 0);
        check("reset strobes", int'({ld_ab, sh_a, sh_b, swap_ab, sub_ba, ld_res, shl_res}), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle without start", int'(busy), 0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, 1'b0);
            check($sformatf("v%0d got_done", i), int'(got_done), 1);
            check($sformatf("v%0d result", i), int'(res), int'(vecs[i].res));
            check($sformatf("v%0d done cycle", i), done_cyc, vecs[i].cyc);
            check($sformatf("v%0d ld_ab count", i), cnt_ld, 1);
            check($sformatf("v%0d sh_ab count", i), cnt_shab, vecs[i].shab);
            check($sformatf("v%0d sh_a count", i), cnt_sha, vecs[i].sha);
            check($sformatf("v%0d sh_b count", i), cnt_shb, vecs[i].shb);
            check($sformatf("v%0d swap count", i), cnt_swap, vecs[i].swp);
            check($sformatf("v%0d sub count", i), cnt_sub, vecs[i].sub);
            check($sformatf("v%0d shl count", i), cnt_shl, vecs[i].shl);
            check($sformatf("v%0d ld_res count", i), cnt_ldres, 1);
            check($sformatf("v%0d res_sel", i), rs_at_ld, vecs[i].rs);
            check($sformatf("v%0d busy gaps", i), busy_low, 0);
            @(negedge clk);
            check($sformatf("v%0d idle after done", i), int'({busy, done}), 0);
        end

        // start held high across a run and past done
        run_op(8'd12, 8'd18, 1'b1);
        check("hold got_done", int'(got_done), 1);
        check("hold ld_ab count", cnt_ld, 1);
        check("hold result", int'(res), 6);
        @(negedge clk);
        check("hold idle after done", int'({busy, ld_ab}), 0);
        @(negedge clk);
        check("hold reload", int'(ld_ab), 1);
        start = 1'b0;
        got_done = 0;
        for (int t = 0; t < 200 && !got_done; t++) begin
            @(negedge clk);
            if (done) got_done = 1;
        end
        check("hold second run done", int'(got_done), 1);
        check("hold second result", int'(res), 6);
        @(negedge clk);

        // reset during SHL with k=3 (A=B=8)
        in_a = 8'd8;
        in_b = 8'd8;
        start = 1'b1;
        got_done = 0;
        begin
            bit seen_shl = 0;
            for (int t = 0; t < 200 && !seen_shl; t++) begin
                @(negedge clk);
                start = 1'b0;
                if (shl_res) seen_shl = 1;
                if (done) got_done = 1;
            end
            check("rst-mid reached SHL", int'(seen_shl), 1);
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst-mid busy", int'(busy), 0);
        check("rst-mid strobes", int'({ld_ab, sh_a, sh_b, swap_ab, sub_ba, ld_res, shl_res, done}), 0);
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (done || busy) got_done = 1;
        end
        check("rst-mid no done", int'(got_done), 0);

        run_op(8'd5, 8'd5, 1'b0);
        check("post-rst got_done", int'(got_done), 1);
        check("post-rst result", int'(res), 5);
        check("post-rst shl count", cnt_shl, 0);
        check("post-rst done cycle", done_cyc, 8);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
